// File: rtl/uart_dma_pkg.sv
// uart_dma_pkg: shared types and constants for the UART boot/run DMA sequencer.
// Contents: sequencer state enum, default acknowledge byte, assembled word width.
package uart_dma_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        LEN,
        LOAD,
        ACK,
        RUN
    } dma_state_t;

endpackage

// File: rtl/uart_dma_sequencer_if.sv
// uart_dma_sequencer_if: UART receive, memory-hub word delivery and UART transmit
// signals of the sequencer.
// master: the sequencer (drives ready pulses, data, program_loaded, tx_start, sdata).
// slave : the surroundings (drive rx_ready/rdata, hub transmit request, tx_busy).
interface uart_dma_sequencer_if;
    import uart_dma_pkg::*;

    logic              rx_ready;
    logic [7:0]        rdata;
    logic              instr_ready;
    logic              mem_ready;
    logic [WORD_W-1:0] data;
    logic              program_loaded;
    logic              hub_tx_start;
    logic [7:0]        hub_sdata;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        sdata;

    modport master (
        input  rx_ready, rdata, hub_tx_start, hub_sdata, tx_busy,
        output instr_ready, mem_ready, data, program_loaded, tx_start, sdata
    );

    modport slave (
        output rx_ready, rdata, hub_tx_start, hub_sdata, tx_busy,
        input  instr_ready, mem_ready, data, program_loaded, tx_start, sdata
    );
endinterface

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs received bytes into 32-bit little-endian words.
// Ports: clock, reset (async, active-high), rx_ready/rdata (byte strobe and byte),
//        word_valid (combinational, high with the 4th byte), word (completed word).
// Optional feature: define UART_DMA_TIMEOUT_EN to discard a partial word after
// TIMEOUT_CYCLES idle cycles between its bytes.
module uart_word_assembler
    import uart_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [7:0]        rdata,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] shreg_q;
    logic        timeout;

    // The 4th byte is taken straight from rdata so the word is ready in its own cycle.
    assign word_valid = rx_ready && (idx_q == 2'd3);
    assign word       = {rdata, shreg_q};

    // Byte index and lower three bytes; the index wraps from 3 to 0 on its own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= 2'd0;
            shreg_q <= 24'd0;
        end else if (rx_ready) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    shreg_q[7:0]   <= rdata;
                2'd1:    shreg_q[15:8]  <= rdata;
                2'd2:    shreg_q[23:16] <= rdata;
                default: ;
            endcase
        end else if (timeout) begin
            idx_q <= 2'd0;
        end
    end

`ifdef UART_DMA_TIMEOUT_EN
    logic [31:0] gap_q;

    assign timeout = (gap_q == TIMEOUT_CYCLES);

    // Idle-gap counter, only running while a word is partially assembled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_q <= 32'd0;
        end else if (rx_ready || (idx_q == 2'd0) || timeout) begin
            gap_q <= 32'd0;
        end else begin
            gap_q <= gap_q + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout = 1'b0;
    // Keeps the timeout parameter referenced when the gap counter is compiled out.
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: rtl/uart_dma_sequencer.sv
// uart_dma_sequencer: boot loader and run-time word forwarder between the UART and
// the memory hub. Loads a length-prefixed program (instr_ready), sends ACK_BYTE,
// then forwards every further word (mem_ready) and hands the transmitter to the hub.
// Ports: clock, reset (async, active-high), bus (uart_dma_sequencer_if.master).
// Optional feature: UART_DMA_TIMEOUT_EN enables the partial-word timeout in the assembler.
module uart_dma_sequencer
    import uart_dma_pkg::*;
#(
    parameter int unsigned CODE_WORDS     = 256,
    parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic                  clock,
    input logic                  reset,
    uart_dma_sequencer_if.master bus
);

    dma_state_t        state_q, state_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [31:0]       waddr_q, waddr_d;
    logic              instr_ready_q, instr_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              program_loaded_q, program_loaded_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        sdata_q, sdata_d;

    logic              word_valid;
    logic [WORD_W-1:0] word;

    uart_word_assembler #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_asm (
        .clock      (clock),
        .reset      (reset),
        .rx_ready   (bus.rx_ready),
        .rdata      (bus.rdata),
        .word_valid (word_valid),
        .word       (word)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= LEN;
            remaining_q      <= 32'd0;
            waddr_q          <= 32'd0;
            instr_ready_q    <= 1'b0;
            mem_ready_q      <= 1'b0;
            data_q           <= '0;
            program_loaded_q <= 1'b0;
            tx_start_q       <= 1'b0;
            sdata_q          <= 8'd0;
        end else begin
            state_q          <= state_d;
            remaining_q      <= remaining_d;
            waddr_q          <= waddr_d;
            instr_ready_q    <= instr_ready_d;
            mem_ready_q      <= mem_ready_d;
            data_q           <= data_d;
            program_loaded_q <= program_loaded_d;
            tx_start_q       <= tx_start_d;
            sdata_q          <= sdata_d;
        end
    end

    // Next state and next register values.
    always_comb begin
        state_d          = state_q;
        remaining_d      = remaining_q;
        waddr_d          = waddr_q;
        instr_ready_d    = 1'b0;
        mem_ready_d      = 1'b0;
        data_d           = data_q;
        program_loaded_d = program_loaded_q;
        tx_start_d       = 1'b0;
        sdata_d          = sdata_q;

        // The length word is never presented on data.
        if (word_valid && (state_q != LEN)) begin
            data_d = word;
        end

        case (state_q)
            LEN: begin
                if (word_valid) begin
                    if (word == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d     = LOAD;
                        remaining_d = word;
                        waddr_d     = 32'd0;
                    end
                end
            end
            LOAD: begin
                if (word_valid) begin
                    // Words past the code segment are counted but not written.
                    instr_ready_d = (waddr_q < CODE_WORDS);
                    waddr_d       = waddr_q + 32'd1;
                    remaining_d   = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                mem_ready_d = word_valid;
                // Stay one extra cycle so the registered ACK pulse is not masked by the hub mux.
                if (tx_start_q) begin
                    state_d = RUN;
                end else if (!bus.tx_busy) begin
                    tx_start_d       = 1'b1;
                    sdata_d          = ACK_BYTE;
                    program_loaded_d = 1'b1;
                end
            end
            RUN: begin
                mem_ready_d = word_valid;
            end
            default: begin
                state_d = LEN;
            end
        endcase
    end

    assign bus.instr_ready    = instr_ready_q;
    assign bus.mem_ready      = mem_ready_q;
    assign bus.data           = data_q;
    assign bus.program_loaded = program_loaded_q;
    // Transmitter belongs to the hub once the boot handshake is finished.
    assign bus.tx_start       = (state_q == RUN) ? bus.hub_tx_start : tx_start_q;
    assign bus.sdata          = (state_q == RUN) ? bus.hub_sdata    : sdata_q;

endmodule

// File: tb/tb_uart_dma_sequencer.sv
// tb_uart_dma_sequencer: scoreboard bench for uart_dma_sequencer (CODE_WORDS=2,
// TIMEOUT_CYCLES=50). Stimulus pushes expected pulses (kind, value, cycle);
// a negedge monitor pops and compares whenever a ready or tx_start pulse shows.
module tb_uart_dma_sequencer;

    localparam int K_NONE  = 0;
    localparam int K_INSTR = 1;
    localparam int K_MEM   = 2;
    localparam int K_TX    = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   compared;
    int   mismatched;
    exp_t exp_q[$];

    uart_dma_sequencer_if bus ();

    uart_dma_sequencer #(
        .CODE_WORDS     (2),
        .ACK_BYTE       (8'hAA),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int kind, input logic [31:0] val, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endfunction

    function automatic void match(input int kind, input logic [31:0] val);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        end
        compared++;
        if (idx < 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse kind=%0d: got value %0h at cycle %0d, expected no pulse", kind, val, cyc);
        end else begin
            if (exp_q[idx].val !== val || exp_q[idx].cyc != cyc) begin
                mismatched++;
                $display("FAIL pulse kind=%0d: got value %0h at cycle %0d expected value %0h at cycle %0d",
                         kind, val, cyc, exp_q[idx].val, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
        end
    endfunction

    // Monitor: flags overdue expectations, then checks every pulse the DUT presents.
    always @(negedge clock) begin
        int i;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL missing_pulse kind=%0d: got nothing expected value %0h at cycle %0d",
                         exp_q[i].kind, exp_q[i].val, exp_q[i].cyc);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
        if (bus.instr_ready && bus.mem_ready) begin
            compared++;
            mismatched++;
            $display("FAIL ready_overlap: got instr_ready=1 mem_ready=1 expected at most one");
        end
        if (bus.instr_ready) match(K_INSTR, bus.data);
        if (bus.mem_ready)   match(K_MEM, bus.data);
        if (bus.tx_start)    match(K_TX, {24'd0, bus.sdata});
    end

    task automatic send_byte(input logic [7:0] b, input int kind, input logic [31:0] w, input bit ack);
        @(negedge clock);
        bus.rx_ready = 1'b1;
        bus.rdata    = b;
        if (kind != K_NONE) push(kind, w, cyc + 1);
        if (ack) push(K_TX, 32'hAA, cyc + 2);
        @(negedge clock);
        bus.rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int kind, input bit ack);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (i == 3) ? kind : K_NONE, w, (i == 3) && ack);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [63:0] all_outputs();
        return {22'd0, bus.instr_ready, bus.mem_ready, bus.program_loaded, bus.tx_start, bus.sdata, bus.data};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1);
    end

    initial begin
        cyc          = 0;
        compared     = 0;
        mismatched   = 0;
        reset        = 1'b1;
        bus.rx_ready     = 1'b0;
        bus.rdata        = 8'd0;
        bus.hub_tx_start = 1'b0;
        bus.hub_sdata    = 8'd0;
        bus.tx_busy      = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b0;

        // Boot with N=2: both words fit, then ACK.
        send_word(32'h0000_0002, K_NONE, 1'b0);
        check("no_output_after_len", all_outputs(), 64'd0);
        send_word(32'h4433_2211, K_INSTR, 1'b0);
        send_word(32'h8877_6655, K_INSTR, 1'b1);
        repeat (3) @(negedge clock);
        check("program_loaded_boot", 64'(bus.program_loaded), 64'd1);

        // Run: two words forwarded to the input ring.
        send_word(32'hCAFE_BABE, K_MEM, 1'b0);
        send_word(32'h1234_5678, K_MEM, 1'b0);

        // Hub owns the transmitter, combinationally.
        @(posedge clock);
        #1;
        push(K_TX, 32'h5A, cyc);
        bus.hub_tx_start = 1'b1;
        bus.hub_sdata    = 8'h5A;
        @(posedge clock);
        #1;
        bus.hub_tx_start = 1'b0;

        // Async reset from RUN clears everything within the cycle.
        @(negedge clock);
        #1 reset = 1'b1;
        #1 check("async_reset_from_run", all_outputs(), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset mid-LOAD after 2 bytes: next 4 bytes are a fresh length.
        send_word(32'h0000_0003, K_NONE, 1'b0);
        send_word(32'h0403_0201, K_INSTR, 1'b0);
        send_byte(8'h77, K_NONE, 32'd0, 1'b0);
        send_byte(8'h66, K_NONE, 32'd0, 1'b0);
        @(negedge clock);
        #1 reset = 1'b1;
        #1 check("async_reset_mid_load", all_outputs(), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        send_word(32'h0000_0001, K_NONE, 1'b0);
        send_word(32'hDDCC_BBAA, K_INSTR, 1'b1);
        repeat (3) @(negedge clock);
        check("program_loaded_after_reload", 64'(bus.program_loaded), 64'd1);

        // N=0 with the transmitter busy: ACK waits for tx_busy to fall.
        do_reset();
        bus.tx_busy = 1'b1;
        send_word(32'h0000_0000, K_NONE, 1'b0);
        repeat (20) @(negedge clock);
        check("tx_start_held_busy", 64'(bus.tx_start), 64'd0);
        check("not_loaded_while_busy", 64'(bus.program_loaded), 64'd0);
        bus.tx_busy = 1'b0;
        push(K_TX, 32'hAA, cyc + 1);
        repeat (4) @(negedge clock);
        check("program_loaded_n0", 64'(bus.program_loaded), 64'd1);

        // N=3 with a 2-word code segment: third word consumed silently.
        do_reset();
        send_word(32'h0000_0003, K_NONE, 1'b0);
        send_word(32'hA1A2_A3A4, K_INSTR, 1'b0);
        send_word(32'hB1B2_B3B4, K_INSTR, 1'b0);
        send_word(32'hC1C2_C3C4, K_NONE, 1'b1);
        repeat (3) @(negedge clock);
        check("program_loaded_overflow", 64'(bus.program_loaded), 64'd1);

`ifdef UART_DMA_TIMEOUT_EN
        // Stale partial word is dropped after the gap.
        send_byte(8'hEE, K_NONE, 32'd0, 1'b0);
        send_byte(8'hFF, K_NONE, 32'd0, 1'b0);
        repeat (60) @(negedge clock);
        send_word(32'h0D0C_0B0A, K_MEM, 1'b0);
`else
        // Without the timeout a partial word waits across a long gap.
        send_byte(8'h01, K_NONE, 32'd0, 1'b0);
        send_byte(8'h02, K_NONE, 32'd0, 1'b0);
        repeat (60) @(negedge clock);
        send_byte(8'h03, K_NONE, 32'd0, 1'b0);
        send_byte(8'h04, K_MEM, 32'h0403_0201, 1'b0);
`endif

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
